// File: rtl/char_cell_plotter.sv
// rtl/char_cell_plotter.sv - walks one 8x8 text cell and drives the 160x120 framebuffer write port
// One pixel per clock from an internal 5x7 glyph ROM; erase mode paints the whole cell background.
module char_cell_plotter #(
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [4:0] char_id,
    input  logic [4:0] col,
    input  logic [3:0] row,
    input  logic       delete,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_DRAW   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  id_q, id_d;
    logic [4:0]  col_q, col_d;
    logic [3:0]  row_q, row_d;
    logic        del_q, del_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [63:0] glyph;

    // Font rows are written visually: 7 rows of 5 bits, leftmost bit is px 0 of row 0.
    function automatic logic [34:0] font(input logic [4:0] id);
        case (id)
            5'd1:    font = 35'b01110_10001_10001_11111_10001_10001_10001;
            5'd2:    font = 35'b11110_10001_10001_11110_10001_10001_11110;
            5'd3:    font = 35'b01110_10001_10000_10000_10000_10001_01110;
            5'd4:    font = 35'b11110_10001_10001_10001_10001_10001_11110;
            5'd5:    font = 35'b11111_10000_10000_11110_10000_10000_11111;
            5'd6:    font = 35'b11111_10000_10000_11110_10000_10000_10000;
            5'd7:    font = 35'b01110_10001_10000_10111_10001_10001_01111;
            5'd8:    font = 35'b10001_10001_10001_11111_10001_10001_10001;
            5'd9:    font = 35'b01110_00100_00100_00100_00100_00100_01110;
            5'd10:   font = 35'b00111_00010_00010_00010_00010_10010_01100;
            5'd11:   font = 35'b10001_10010_10100_11000_10100_10010_10001;
            5'd12:   font = 35'b10000_10000_10000_10000_10000_10000_11111;
            5'd13:   font = 35'b10001_11011_10101_10101_10001_10001_10001;
            5'd14:   font = 35'b10001_10001_11001_10101_10011_10001_10001;
            5'd15:   font = 35'b01110_10001_10001_10001_10001_10001_01110;
            5'd16:   font = 35'b11110_10001_10001_11110_10000_10000_10000;
            5'd17:   font = 35'b01110_10001_10001_10001_10101_10010_01101;
            5'd18:   font = 35'b11110_10001_10001_11110_10100_10010_10001;
            5'd19:   font = 35'b01111_10000_10000_01110_00001_00001_11110;
            5'd20:   font = 35'b11111_00100_00100_00100_00100_00100_00100;
            5'd21:   font = 35'b10001_10001_10001_10001_10001_10001_01110;
            5'd22:   font = 35'b10001_10001_10001_10001_10001_01010_00100;
            5'd23:   font = 35'b10001_10001_10001_10101_10101_10101_01010;
            5'd24:   font = 35'b10001_10001_01010_00100_01010_10001_10001;
            5'd25:   font = 35'b10001_10001_01010_00100_00100_00100_00100;
            5'd26:   font = 35'b11111_00001_00010_00100_01000_10000_11111;
            default: font = 35'b0;
        endcase
    endfunction

    // Spread into the 64-bit cell layout (bit py*8+px); row 7 and columns 5..7 stay clear.
    function automatic logic [63:0] expand(input logic [34:0] f);
        logic [63:0] g;
        g = 64'b0;
        for (int py = 0; py < 7; py++) begin
            for (int px = 0; px < 5; px++) begin
                g[py*8+px] = f[34-(py*5+px)];
            end
        end
        return g;
    endfunction

    assign glyph = expand(font(id_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        col_d    = col_q;
        row_d    = row_q;
        del_d    = del_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        busy_d   = busy_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (col <= 5'd19 && row <= 4'd14) begin
                        id_d    = char_id;
                        col_d   = col;
                        row_d   = row;
                        del_d   = delete;
                        cnt_d   = 6'd0;
                        busy_d  = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP, S_DRAW: begin
                // Pixel 0 leaves on the SETUP->DRAW edge so the 64 plots land on E1..E64.
                x_d      = {col_q, cnt_q[2:0]};
                y_d      = {row_q, cnt_q[5:3]};
                colour_d = (!del_q && glyph[cnt_q]) ? FG_COLOUR : BG_COLOUR;
                plot_d   = 1'b1;
                cnt_d    = cnt_q + 6'd1;
                if (state_q == S_SETUP) begin
                    state_d = S_DRAW;
                end else if (cnt_q == 6'd63) begin
                    state_d = S_FINISH;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            id_q     <= 5'd0;
            col_q    <= 5'd0;
            row_q    <= 4'd0;
            del_q    <= 1'b0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            col_q    <= col_d;
            row_q    <= row_d;
            del_q    <= del_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_char_cell_plotter.sv
// tb/tb_char_cell_plotter.sv - randomized self-checking bench for char_cell_plotter
module tb_char_cell_plotter;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [4:0] char_id;
    logic [4:0] col;
    logic [3:0] row;
    logic       delete;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cyc = 0;
    logic [34:0] font [1:26];

    char_cell_plotter dut (
        .clk(clk), .resetn(resetn), .start(start), .char_id(char_id),
        .col(col), .row(row), .delete(delete),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pixel colour from the letter bitmaps: 5 columns x 7 rows, all else background.
    function automatic logic [2:0] ref_colour(input int id, input int py, input int px, input bit del);
        if (del) return 3'b000;
        if (id < 1 || id > 26 || py > 6 || px > 4) return 3'b000;
        return font[id][34-(py*5+px)] ? 3'b111 : 3'b000;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_x"}, vga_x, 0);
        check({tag, "_y"}, vga_y, 0);
        check({tag, "_colour"}, vga_colour, 0);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic launch(input int id, input int c, input int r, input bit d);
        start = 1'b1; char_id = 5'(id); col = 5'(c); row = 4'(r); delete = d;
        tick();
        check("accept_busy", busy, 1);
        check("accept_plot", plot, 0);
    endtask

    task automatic scramble_inputs();
        start = 1'b0; char_id = 5'($urandom); col = 5'($urandom);
        row = 4'($urandom); delete = 1'($urandom);
    endtask

    // Checks E1..E65 of a request already accepted at E0.
    task automatic check_cell(input int id, input int c, input int r, input bit d, input bit intrude);
        for (int i = 0; i < 64; i++) begin
            tick();
            if (intrude && i == 11) start = 1'b0;
            check("pix_plot", plot, 1);
            check("pix_x", vga_x, c * 8 + i % 8);
            check("pix_y", vga_y, r * 8 + i / 8);
            check("pix_colour", vga_colour, ref_colour(id, i / 8, i % 8, d));
            check("pix_busy", busy, 1);
            check("pix_done", done, 0);
            if (intrude && i == 10) begin
                start = 1'b1; col = 5'd3; row = 4'd1; char_id = 5'd9; delete = 1'b0;
            end
        end
        tick();
        check("fin_plot", plot, 0);
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        done_cyc = cyc;
    endtask

    task automatic draw(input int id, input int c, input int r, input bit d, input bit intrude);
        launch(id, c, r, d);
        scramble_inputs();
        check_cell(id, c, r, d, intrude);
        tick();
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_plot", plot, 0);
    endtask

    task automatic reject(input int c, input int r);
        start = 1'b1; col = 5'(c); row = 4'(r); char_id = 5'($urandom); delete = 1'($urandom);
        tick();
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        check("rej_plot", plot, 0);
        start = 1'b0;
        tick();
        check("rej_err_clear", err, 0);
        check("rej_busy2", busy, 0);
        check("rej_plot2", plot, 0);
    endtask

    initial begin
        int t1;
        int seen;
        font[1]  = 35'b01110_10001_10001_11111_10001_10001_10001;
        font[2]  = 35'b11110_10001_10001_11110_10001_10001_11110;
        font[3]  = 35'b01110_10001_10000_10000_10000_10001_01110;
        font[4]  = 35'b11110_10001_10001_10001_10001_10001_11110;
        font[5]  = 35'b11111_10000_10000_11110_10000_10000_11111;
        font[6]  = 35'b11111_10000_10000_11110_10000_10000_10000;
        font[7]  = 35'b01110_10001_10000_10111_10001_10001_01111;
        font[8]  = 35'b10001_10001_10001_11111_10001_10001_10001;
        font[9]  = 35'b01110_00100_00100_00100_00100_00100_01110;
        font[10] = 35'b00111_00010_00010_00010_00010_10010_01100;
        font[11] = 35'b10001_10010_10100_11000_10100_10010_10001;
        font[12] = 35'b10000_10000_10000_10000_10000_10000_11111;
        font[13] = 35'b10001_11011_10101_10101_10001_10001_10001;
        font[14] = 35'b10001_10001_11001_10101_10011_10001_10001;
        font[15] = 35'b01110_10001_10001_10001_10001_10001_01110;
        font[16] = 35'b11110_10001_10001_11110_10000_10000_10000;
        font[17] = 35'b01110_10001_10001_10001_10101_10010_01101;
        font[18] = 35'b11110_10001_10001_11110_10100_10010_10001;
        font[19] = 35'b01111_10000_10000_01110_00001_00001_11110;
        font[20] = 35'b11111_00100_00100_00100_00100_00100_00100;
        font[21] = 35'b10001_10001_10001_10001_10001_10001_01110;
        font[22] = 35'b10001_10001_10001_10001_10001_01010_00100;
        font[23] = 35'b10001_10001_10001_10101_10101_10101_01010;
        font[24] = 35'b10001_10001_01010_00100_01010_10001_10001;
        font[25] = 35'b10001_10001_01010_00100_00100_00100_00100;
        font[26] = 35'b11111_00001_00010_00100_01000_10000_11111;

        resetn = 1'b0; start = 1'b0; char_id = 5'd0; col = 5'd0; row = 4'd0; delete = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        resetn = 1'b1;
        tick();

        draw(1, 0, 0, 1'b0, 1'b0);
        draw(5, 19, 14, 1'b1, 1'b0);
        reject(20, 0);
        reject(0, 15);
        reject(31, 15);
        draw(2, 7, 4, 1'b0, 1'b1);

        // Reset in the middle of a cell aborts it silently.
        launch(13, 4, 5, 1'b0);
        scramble_inputs();
        repeat (31) tick();
        check("mid_x", vga_x, 4 * 8 + 30 % 8);
        #2 resetn = 1'b0;
        #1 check_idle_outputs("mid_reset");
        tick();
        resetn = 1'b1;
        seen = 0;
        repeat (70) begin
            tick();
            if (done || plot || busy) seen++;
        end
        check("after_reset_quiet", seen, 0);
        draw(26, 10, 7, 1'b0, 1'b0);

        // start held high: the second cell is accepted on the first IDLE edge.
        start = 1'b1; char_id = 5'd15; col = 5'd2; row = 4'd3; delete = 1'b0;
        tick();
        check("held_busy", busy, 1);
        col = 5'd3; char_id = 5'd23;
        check_cell(15, 2, 3, 1'b0, 1'b0);
        t1 = done_cyc;
        tick();
        check("held_reaccept_busy", busy, 1);
        check("held_reaccept_done", done, 0);
        scramble_inputs();
        check_cell(23, 3, 3, 1'b0, 1'b0);
        check("held_done_spacing", done_cyc - t1, 66);
        tick();
        check("held_end_busy", busy, 0);

        for (int k = 0; k < 6; k++) begin
            draw(int'($urandom_range(31, 0)), int'($urandom_range(19, 0)),
                 int'($urandom_range(14, 0)), 1'($urandom), 1'b0);
            repeat ($urandom_range(3, 0)) begin
                tick();
                check("gap_busy", busy, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/char_cell_plotter.md
# char_cell_plotter

Consumes one character-draw request (glyph id, text-grid cell, erase flag) and walks the 8×8 pixel cell. It looks up each pixel in an internal glyph ROM and emits absolute framebuffer coordinates, colour and a plot strobe, one pixel per clock. It sits between the word/character sequencing logic and the VGA framebuffer write port (160×120, 3-bit colour), which it drives directly.

## Interface
- FG_COLOUR, 3'b111, colour for set glyph bits
- BG_COLOUR, 3'b000, colour for clear glyph bits and for all pixels when erasing
- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request strobe, sampled only while busy=0
- char_id  in  5  glyph id: 0 space, 1–26 A–Z, 27–31 blank
- col  in  5  text-grid column, valid 0–19
- row  in  4  text-grid row, valid 0–14
- delete  in  1  1 = erase cell (every pixel BG_COLOUR)
- vga_x  out  8  absolute pixel x = col*8 + px
- vga_y  out  7  absolute pixel y = row*8 + py
- vga_colour  out  3  pixel colour
- plot  out  1  framebuffer write enable, valid with vga_x/vga_y/vga_colour
- busy  out  1  request in progress
- done  out  1  one-cycle pulse after last pixel
- err  out  1  one-cycle pulse: start rejected (col>19 or row>14)

## Operation
- FSM states: IDLE, SETUP, DRAW, FINISH.
- IDLE: on start=1 with col≤19 and row≤14:
  - register char_id, col, row, delete;
  - clear the 6-bit pixel counter (py = cnt[5:3], px = cnt[2:0]);
  - go to SETUP.
- IDLE with start=1 and an out-of-range cell: stay in IDLE, pulse err for 1 cycle, do not plot.
- SETUP: one cycle for the glyph ROM row fetch; go to DRAW.
- DRAW: each cycle, emit the pixel for the current cnt and increment cnt. Order is row-major: px 0→7, then py+1.
  - Leave DRAW after cnt=63 is emitted.
- FINISH: one cycle; done=1, busy drops. Return to IDLE.
- Colour per pixel:
  - delete=1: BG_COLOUR.
  - delete=0: glyph bit at (py,px) = 1 gives FG_COLOUR, 0 gives BG_COLOUR.
  - The cell is always fully overwritten.
- Glyph ROM: combinational, 32×64 bits, bit index py*8+px. Bit 0 is top-left.
  - Ids 0 and 27–31 are all-zero.
  - Row 7 and column 7 of every glyph are zero (inter-character spacing).
- Address arithmetic is width-exact with no wrap: max vga_x = 159, max vga_y = 119.
- start, col, row, char_id and delete are ignored while busy=1. Inputs may change freely after the accepting edge.

## Timing
- Reset (resetn=0, any state, immediate): state=IDLE, cnt=0.
  - Outputs: vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0, err=0.
  - A reset mid-draw aborts the draw with no done pulse.
- Edge E0 samples start: busy=1 and plot=0 after E0.
- Edges E1…E64 present pixels 0…63, registered, with plot=1.
- Edge E65: plot=0, done=1, busy=0.
- Edge E66: done=0. A start sampled at E66 is accepted (busy=0).
- Throughput: one request per 66 cycles, 64 plots per request.
- start held high continuously: re-accepted at every IDLE cycle, so back-to-back draws run with no gap beyond FINISH.
- err asserts the cycle after the rejecting edge, for 1 cycle. busy stays 0.

## Test plan
- Reset mid-draw: assert resetn=0 at pixel 30 → all outputs 0 immediately; after release, idle with no done pulse; next start draws normally.
- Draw char_id=1 ('A'), col=0, row=0, delete=0:
  - exactly 64 plots, x 0–7 and y 0–7 row-major;
  - colours match the ROM 'A' bitmap, with row 7 all 3'b000;
  - done one cycle after the last plot.
- Erase cell col=19, row=14, delete=1, char_id=5 → 64 plots at x 152–159, y 112–119, all colour 3'b000.
- Out of range: start with col=20 → err pulse; no plot, busy stays 0. Repeat with row=15 → same.
- Pulse start again while busy at pixel 10 with col=3 → ignored. Only the original cell is drawn; one done.
- start held high with col alternating 2/3 → two consecutive cells drawn (x 16–23, then 24–31); done pulses 66 cycles apart.
